// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the execute hazard controller
package core_pkg;

  localparam int REG_ADDR_W = 4;

  // Operand mux selects: register file, MEM-stage result, WB-stage result
  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // NZCV bit positions inside the status register
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/exe_hazard_ctrl_if.sv
// rtl/exe_hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface exe_hazard_ctrl_if
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic                  fwd_en;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_r_en;
  logic                  exe_s;
  logic [3:0]            exe_status;
  logic [REG_ADDR_W-1:0] exe_src1;
  logic [REG_ADDR_W-1:0] exe_src2;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  wb_wb_en;
  logic                  branch_taken;

  logic                  freeze;
  logic                  flush;
  logic [1:0]            sel_src1;
  logic [1:0]            sel_src2;
  logic [3:0]            sr;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  // Pipeline side: drives stage information, consumes controls
  modport master (
    output fwd_en, id_src1, id_src2, id_two_src, id_valid,
           exe_dest, exe_wb_en, exe_mem_r_en, exe_s, exe_status, exe_src1, exe_src2,
           mem_dest, mem_wb_en, wb_dest, wb_wb_en, branch_taken,
    input  freeze, flush, sel_src1, sel_src2, sr, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  fwd_en, id_src1, id_src2, id_two_src, id_valid,
           exe_dest, exe_wb_en, exe_mem_r_en, exe_s, exe_status, exe_src1, exe_src2,
           mem_dest, mem_wb_en, wb_dest, wb_wb_en, branch_taken,
    output freeze, flush, sel_src1, sel_src2, sr, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/exe_hazard_ctrl_fwd_unit.sv
// rtl/exe_hazard_ctrl_fwd_unit.sv - combinational forwarding selects for the EXE operand muxes
module fwd_unit
  import core_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] exe_src1,
  input  logic [REG_ADDR_W-1:0] exe_src2,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  wb_wb_en,
  output logic [1:0]            sel_src1,
  output logic [1:0]            sel_src2
);

  // MEM is the younger producer, so it wins over WB on a double match
  always_comb begin
    sel_src1 = SEL_REG;
    sel_src2 = SEL_REG;
    if (en) begin
      if (mem_wb_en && exe_src1 == mem_dest)     sel_src1 = SEL_MEM;
      else if (wb_wb_en && exe_src1 == wb_dest)  sel_src1 = SEL_WB;
      if (mem_wb_en && exe_src2 == mem_dest)     sel_src2 = SEL_MEM;
      else if (wb_wb_en && exe_src2 == wb_dest)  sel_src2 = SEL_WB;
    end
  end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// rtl/exe_hazard_ctrl.sv - hazard detection, stall/flush FSM, NZCV register and perf counters
module exe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  exe_hazard_ctrl_if.slave   bus
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            state;
  logic [FL_W-1:0]   flush_left;
  logic [3:0]        sr;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              m1;
  logic              m2;
  logic              hazard;
  logic              freeze;
  logic              flush;
  logic [1:0]        sel_src1;
  logic [1:0]        sel_src2;

  // RAW match of ID operands against EXE/MEM destinations; loads stall even when forwarding
  always_comb begin
    m1 = bus.id_valid & bus.exe_wb_en &
         ((bus.id_src1 == bus.exe_dest) | (bus.id_two_src & (bus.id_src2 == bus.exe_dest)));
    m2 = bus.id_valid & bus.mem_wb_en &
         ((bus.id_src1 == bus.mem_dest) | (bus.id_two_src & (bus.id_src2 == bus.mem_dest)));
    hazard = bus.fwd_en ? (m1 & bus.exe_mem_r_en) : (m1 | m2);
  end

  // Controls are combinational from state; a taken branch outranks a stall
  always_comb begin
    freeze = 1'b0;
    flush  = 1'b0;
    if (!rst) begin
      if (state == FLUSH) begin
        flush = 1'b1;
      end else begin
        flush  = bus.branch_taken;
        freeze = hazard & ~bus.branch_taken;
      end
    end
  end

  fwd_unit u_fwd (
    .en        (bus.fwd_en & ~rst),
    .exe_src1  (bus.exe_src1),
    .exe_src2  (bus.exe_src2),
    .mem_dest  (bus.mem_dest),
    .mem_wb_en (bus.mem_wb_en),
    .wb_dest   (bus.wb_dest),
    .wb_wb_en  (bus.wb_wb_en),
    .sel_src1  (sel_src1),
    .sel_src2  (sel_src2)
  );

  // Multi-cycle flush sequencing; branches seen while flushing are bubbles and ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.branch_taken && FLUSH_CYCLES > 1) begin
            state      <= FLUSH;
            flush_left <= FL_W'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          flush_left <= flush_left - FL_W'(1);
          if (flush_left == FL_W'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Status register and saturating stall/flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.exe_s && !flush) sr <= bus.exe_status;
      if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.freeze    = freeze;
  assign bus.flush     = flush;
  assign bus.sel_src1  = sel_src1;
  assign bus.sel_src2  = sel_src2;
  assign bus.sr        = sr;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// tb/tb_exe_hazard_ctrl.sv - scoreboard bench for exe_hazard_ctrl
module tb_exe_hazard_ctrl;

  localparam int FC    = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    bit       rst;
    bit       fwd_en;
    bit [3:0] id_src1;
    bit [3:0] id_src2;
    bit       id_two_src;
    bit       id_valid;
    bit [3:0] exe_dest;
    bit       exe_wb_en;
    bit       exe_mem_r_en;
    bit       exe_s;
    bit [3:0] exe_status;
    bit [3:0] exe_src1;
    bit [3:0] exe_src2;
    bit [3:0] mem_dest;
    bit       mem_wb_en;
    bit [3:0] wb_dest;
    bit       wb_wb_en;
    bit       branch_taken;
  } stim_t;

  typedef struct {
    bit       freeze;
    bit       flush;
    bit [1:0] sel1;
    bit [1:0] sel2;
    bit [3:0] sr;
    int       stall;
    int       flushc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  exe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  expq[$];
  int    n_pass = 0;
  int    n_total = 0;

  // reference model state
  int    m_rem = 0;
  int    m_sr = 0;
  int    m_stall = 0;
  int    m_flush = 0;
  stim_t prev_s;
  exp_t  prev_e;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // monitor: pops one expectation per cycle, compares away from the active edge
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("freeze",    int'(bus.freeze),    int'(e.freeze));
      check("flush",     int'(bus.flush),     int'(e.flush));
      check("sel_src1",  int'(bus.sel_src1),  int'(e.sel1));
      check("sel_src2",  int'(bus.sel_src2),  int'(e.sel2));
      check("sr",        int'(bus.sr),        int'(e.sr));
      check("stall_cnt", int'(bus.stall_cnt), e.stall);
      check("flush_cnt", int'(bus.flush_cnt), e.flushc);
    end
  end

  function automatic bit reads(input stim_t s, input bit [3:0] d);
    return s.id_src1 == d || (s.id_two_src && s.id_src2 == d);
  endfunction

  function automatic bit [1:0] fwd_of(input stim_t s, input bit [3:0] src);
    if (!s.fwd_en || s.rst) return 2'd0;
    if (s.mem_wb_en && src == s.mem_dest) return 2'd1;
    if (s.wb_wb_en && src == s.wb_dest) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t expect_of(input stim_t s);
    exp_t e;
    bit exe_hit, mem_hit, stall_need;
    exe_hit = s.id_valid && s.exe_wb_en && reads(s, s.exe_dest);
    mem_hit = s.id_valid && s.mem_wb_en && reads(s, s.mem_dest);
    stall_need = s.fwd_en ? (exe_hit && s.exe_mem_r_en) : (exe_hit || mem_hit);
    e.flush  = !s.rst && (m_rem > 0 || s.branch_taken);
    e.freeze = !s.rst && m_rem == 0 && !s.branch_taken && stall_need;
    e.sel1   = fwd_of(s, s.exe_src1);
    e.sel2   = fwd_of(s, s.exe_src2);
    e.sr     = 4'(m_sr);
    e.stall  = m_stall;
    e.flushc = m_flush;
    return e;
  endfunction

  // advance model across one clock edge given the inputs/outputs of the cycle before it
  task automatic model_edge(input stim_t s, input exp_t e);
    if (s.rst) begin
      m_rem = 0; m_sr = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (s.exe_s && !e.flush) m_sr = int'(s.exe_status);
      if (e.freeze && m_stall < CMAX) m_stall++;
      if (e.flush && m_flush < CMAX) m_flush++;
      if (m_rem > 0) m_rem--;
      else if (s.branch_taken) m_rem = FC - 1;
    end
  endtask

  task automatic apply(input stim_t s);
    rst              = s.rst;
    bus.fwd_en       = s.fwd_en;
    bus.id_src1      = s.id_src1;
    bus.id_src2      = s.id_src2;
    bus.id_two_src   = s.id_two_src;
    bus.id_valid     = s.id_valid;
    bus.exe_dest     = s.exe_dest;
    bus.exe_wb_en    = s.exe_wb_en;
    bus.exe_mem_r_en = s.exe_mem_r_en;
    bus.exe_s        = s.exe_s;
    bus.exe_status   = s.exe_status;
    bus.exe_src1     = s.exe_src1;
    bus.exe_src2     = s.exe_src2;
    bus.mem_dest     = s.mem_dest;
    bus.mem_wb_en    = s.mem_wb_en;
    bus.wb_dest      = s.wb_dest;
    bus.wb_wb_en     = s.wb_wb_en;
    bus.branch_taken = s.branch_taken;
  endtask

  task automatic cyc(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge(prev_s, prev_e);
    apply(s);
    e = expect_of(s);
    expq.push_back(e);
    prev_s = s;
    prev_e = e;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.id_src1 = 4'd14; s.id_src2 = 4'd14;
    s.exe_src1 = 4'd13; s.exe_src2 = 4'd13;
    s.exe_dest = 4'd1; s.mem_dest = 4'd2; s.wb_dest = 4'd4;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst          = ($urandom_range(0, 59) == 0);
    s.fwd_en       = 1'($urandom);
    s.id_src1      = 4'($urandom_range(0, 3));
    s.id_src2      = 4'($urandom_range(0, 3));
    s.id_two_src   = 1'($urandom);
    s.id_valid     = ($urandom_range(0, 3) != 0);
    s.exe_dest     = 4'($urandom_range(0, 3));
    s.exe_wb_en    = 1'($urandom);
    s.exe_mem_r_en = 1'($urandom);
    s.exe_s        = 1'($urandom);
    s.exe_status   = 4'($urandom);
    s.exe_src1     = 4'($urandom_range(0, 3));
    s.exe_src2     = 4'($urandom_range(0, 3));
    s.mem_dest     = 4'($urandom_range(0, 3));
    s.mem_wb_en    = 1'($urandom);
    s.wb_dest      = 4'($urandom_range(0, 3));
    s.wb_wb_en     = 1'($urandom);
    s.branch_taken = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    apply(s);
    prev_s = s;
    prev_e = '{default: 0};
    cyc(s);
    cyc(s);

    // stall-only RAW on EXE destination
    s = idle(); s.exe_wb_en = 1; s.exe_dest = 3; s.id_src1 = 3; s.id_valid = 1;
    repeat (3) cyc(s);

    // load-use with forwarding: one stall, then bubble clears EXE
    s = idle(); s.fwd_en = 1; s.exe_wb_en = 1; s.exe_mem_r_en = 1; s.exe_dest = 5;
    s.id_src2 = 5; s.id_two_src = 1; s.id_valid = 1;
    cyc(s);
    s.exe_mem_r_en = 0;
    cyc(s);

    // forwarding priority MEM over WB, then WB only
    s = idle(); s.fwd_en = 1; s.exe_src1 = 2; s.mem_dest = 2; s.wb_dest = 2;
    s.mem_wb_en = 1; s.wb_wb_en = 1;
    cyc(s);
    s.mem_wb_en = 0;
    cyc(s);

    // taken branch coincident with a hazard, then a branch inside the flush window
    s = idle(); s.exe_wb_en = 1; s.exe_dest = 3; s.id_src1 = 3; s.id_valid = 1;
    s.branch_taken = 1;
    cyc(s);
    s.branch_taken = 0;
    cyc(s);
    s.branch_taken = 1;
    cyc(s);
    s = idle();
    repeat (2) cyc(s);

    // status register load, hold, and gating by flush
    s = idle(); s.exe_s = 1; s.exe_status = 4'b1010;
    cyc(s);
    s.exe_s = 0; s.exe_status = 4'b0101;
    cyc(s);
    s.exe_s = 1; s.exe_status = 4'b0011; s.branch_taken = 1;
    cyc(s);
    s = idle();
    repeat (3) cyc(s);

    // reset in the middle of a flush window
    s = idle(); s.branch_taken = 1;
    cyc(s);
    s = idle(); s.rst = 1;
    cyc(s);
    s = idle();
    repeat (2) cyc(s);

    // drive both counters into saturation
    s = idle(); s.exe_wb_en = 1; s.exe_dest = 3; s.id_src1 = 3; s.id_valid = 1;
    repeat (CMAX + 4) cyc(s);
    s = idle(); s.branch_taken = 1;
    repeat (CMAX + 4) cyc(s);

    for (int i = 0; i < 400; i++) cyc(rand_stim());

    @(negedge clk);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
